// File: rtl/dp_array_wr_sched.sv
// dp_array_wr_sched
// Write-port scheduler for an 8-entry, single-write/dual-read cache data array.
// Two requesters share the array's single write port:
//   - line fill from memory (fill_*)
//   - CPU store-merge (st_*)
// A sequenced flush writes zero to all 8 entries, one entry per cycle.
// The read ports do not pass through this block.
//
// Ports:
//   clk, reset                       clock and synchronous active-high reset
//   fill_req/fill_index/fill_data    fill request, held until fill_ack
//   fill_ack                         pulse: fill written at this cycle's closing edge
//   st_req/st_index/st_data          store request, held until st_ack
//   st_ack                           pulse: store written at this cycle's closing edge
//   flush_req                        zero-all request, only looked at in IDLE
//   flush_busy                       high for the 8 flush write cycles
//   flush_done                       pulse in the cycle after the last flush write
//   arr_write/arr_index/arr_datain   array write port
module dp_array_wr_sched #(
    parameter int width = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fill_req,
    input  logic [2:0]       fill_index,
    input  logic [width-1:0] fill_data,
    output logic             fill_ack,
    input  logic             st_req,
    input  logic [2:0]       st_index,
    input  logic [width-1:0] st_data,
    output logic             st_ack,
    input  logic             flush_req,
    output logic             flush_busy,
    output logic             flush_done,
    output logic             arr_write,
    output logic [2:0]       arr_index,
    output logic [width-1:0] arr_datain
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] cnt;
    logic       rr;

    logic       arb_open;
    logic       grant_fill;
    logic       grant_st;
    logic       flushing;

    // Arbitration is open in DONE and in IDLE, except the IDLE cycle that
    // accepts a flush: that cycle is spent switching to FLUSH and grants
    // nothing. On a tie rr picks the winner (0 = fill, 1 = store), so the
    // loser always wins the following cycle. Everything is gated by reset so
    // no write or ack leaks out while reset is held.
    always_comb begin
        arb_open   = !reset && ((state == DONE) ||
                                ((state == IDLE) && !flush_req));
        grant_fill = arb_open && fill_req && (!st_req || !rr);
        grant_st   = arb_open && st_req && (!fill_req || rr);
        flushing   = !reset && (state == FLUSH);
    end

    // Write-port mux. The grant path has zero latency, so the outputs are
    // decoded from current state and requests, not registered. When nothing
    // is granted the port is driven to all zeros instead of holding stale
    // index/data, which keeps the array inputs quiet on idle cycles.
    always_comb begin
        arr_write  = 1'b0;
        arr_index  = 3'd0;
        arr_datain = '0;
        if (flushing) begin
            arr_write  = 1'b1;
            arr_index  = cnt;
            arr_datain = '0;
        end else if (grant_fill) begin
            arr_write  = 1'b1;
            arr_index  = fill_index;
            arr_datain = fill_data;
        end else if (grant_st) begin
            arr_write  = 1'b1;
            arr_index  = st_index;
            arr_datain = st_data;
        end
        fill_ack   = grant_fill;
        st_ack     = grant_st;
        flush_busy = flushing;
        flush_done = !reset && (state == DONE);
    end

    // Sequencer. rr remembers the last winner: a fill grant hands priority
    // to the store side and vice versa. FLUSH steps cnt through 0..7; the
    // write at cnt==7 is the last one, after which cnt has wrapped back to 0
    // and DONE takes one cycle. A reset in the middle of FLUSH simply
    // returns to IDLE; entries already zeroed stay zeroed and there is no
    // flush_done for the aborted flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
            rr    <= 1'b0;
        end else begin
            if (grant_fill) begin
                rr <= 1'b1;
            end else if (grant_st) begin
                rr <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        state <= FLUSH;
                        cnt   <= 3'd0;
                    end
                end
                FLUSH: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

endmodule
